// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default line timing
// and pointer sizing used by the receiver, transmitter and FIFOs.
package uart_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int BAUD_RATE  = 9600;
  localparam int CLOCK_HZ   = 12_000_000;

  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port byte storage: synchronous write,
// asynchronous read so the FIFO head falls through.
module fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = ptr_bits(DEPTH)
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [ADDR_BITS-1:0]  write_addr,
  input  logic [BYTE_WIDTH-1:0] write_data,
  input  logic [ADDR_BITS-1:0]  read_addr,
  output logic [BYTE_WIDTH-1:0] read_data
);

  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/rx_fifo.sv
// Receive byte buffer behind the UART receiver: FWFT read port,
// drops bytes when full and records that in a sticky flag.
module rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH      = 16,
  localparam int ADDR_BITS  = ptr_bits(DEPTH),
  localparam int COUNT_BITS = ADDR_BITS + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_byte,
  output logic                  out_valid,
  output logic [BYTE_WIDTH-1:0] out_byte,
  input  logic                  out_ready,
  output logic [COUNT_BITS-1:0] count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_wr;
  logic                 do_rd;
  logic                 drop;

  assign empty     = (count == '0);
  assign full      = (count == COUNT_BITS'(DEPTH));
  assign out_valid = ~empty;

  // A read frees a slot in the same cycle, so full+read still accepts.
  assign do_rd = out_valid & out_ready;
  assign do_wr = in_valid & (~full | do_rd);
  assign drop  = in_valid & full & ~do_rd;

  fifo_ram #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock      (clock),
    .write_en   (do_wr),
    .write_addr (wr_ptr),
    .write_data (in_byte),
    .read_addr  (rd_ptr),
    .read_data  (out_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Scenario bench for rx_fifo: scoreboard queue of accepted
// bytes checked against the FWFT head as it is drained.
module tb_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CB    = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic          out_ready = 1'b0;
  logic [CB-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int mcount   = 0;
  logic [7:0] sb [$];
  logic [7:0] last_rd;

  rx_fifo #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_byte        (in_byte),
    .out_valid      (out_valid),
    .out_byte       (out_byte),
    .out_ready      (out_ready),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    if (mcount < DEPTH) begin
      sb.push_back(b);
      mcount++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd(input string tag);
    logic [7:0] exp;
    exp = (sb.size() > 0) ? sb[0] : 8'hxx;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid got %b want 1", tag, out_valid);
    end
    n_checks++;
    if (sb.size() == 0 || out_byte !== exp) begin
      n_fail++;
      $display("FAIL %s out_byte got %h want %h", tag, out_byte, exp);
    end
    last_rd   = out_byte;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (sb.size() > 0) begin
      void'(sb.pop_front());
      mcount--;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) rd(tag);
    n_checks++;
    if (out_valid !== 1'b0 || count !== 0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end valid/count/empty got %b/%0d/%b want 0/0/1",
               tag, out_valid, count, empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if ({count, empty, full, out_valid, overflow} !== {5'd0, 4'b1000}) begin
      n_fail++;
      $display("FAIL reset cnt/e/f/v/o got %0d/%b/%b/%b/%b want 0/1/0/0/0",
               count, empty, full, out_valid, overflow);
    end
  endtask

  task automatic test_single();
    wr(8'h41);
    n_checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h41 || count !== 1) begin
      n_fail++;
      $display("FAIL fwft v/byte/cnt got %b/%h/%0d want 1/41/1",
               out_valid, out_byte, count);
    end
    drain("single");
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    n_checks++;
    if (full !== 1'b1 || count !== 16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill f/cnt/o got %b/%0d/%b want 1/16/0",
               full, count, overflow);
    end
    wr(8'hAA);
    n_checks++;
    if (overflow !== 1'b1 || count !== 16) begin
      n_fail++;
      $display("FAIL drop o/cnt got %b/%0d want 1/16", overflow, count);
    end
    drain("fill");
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky overflow got %b want 1", overflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) wr(8'(8'h20 + i));
    drain("wrap_a");
    for (int i = 0; i < 12; i++) wr(8'(8'h80 + i));
    n_checks++;
    if (count !== 12) begin
      n_fail++;
      $display("FAIL wrap_cnt got %0d want 12", count);
    end
    drain("wrap_b");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    n_checks++;
    if (out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_head got %h want 00", out_byte);
    end
    in_valid  = 1'b1;
    in_byte   = 8'h55;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h55);
    n_checks++;
    if (count !== 16 || overflow !== 1'b1 || out_byte !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b cnt/o/head got %0d/%b/%h want 16/1/01",
               count, overflow, out_byte);
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear got %b want 0", overflow);
    end
    in_valid  = 1'b1;
    in_byte   = 8'h66;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h66);
    n_checks++;
    if (count !== 16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_noovf cnt/o got %0d/%b want 16/0", count, overflow);
    end
    drain("b2b");
    n_checks++;
    if (last_rd !== 8'h66) begin
      n_fail++;
      $display("FAIL b2b_last got %h want 66", last_rd);
    end
  endtask

  task automatic test_overflow_clear();
    for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i));
    in_valid       = 1'b1;
    in_byte        = 8'hEE;
    clear_overflow = 1'b1;
    step();
    in_valid       = 1'b0;
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 16) begin
      n_fail++;
      $display("FAIL set_wins o/cnt got %b/%0d want 1/16", overflow, count);
    end
    drain("ovf");
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    n_checks++;
    if (count !== 5) begin
      n_fail++;
      $display("FAIL pre_reset cnt got %0d want 5", count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (count !== 0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset cnt/v/o got %0d/%b/%b want 0/0/0",
               count, out_valid, overflow);
    end
    sb.delete();
    mcount = 0;
    step();
    reset = 1'b1;
    step();
    wr(8'h77);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_back_to_back();
    test_overflow_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver in the UART design. It captures every single-cycle valid/byte pulse from the receiver and holds the bytes in a circular FIFO. Consumers drain it through a first-word-fall-through ready/valid read port. The receiver has no backpressure, so a byte that arrives while the FIFO is full is dropped and flagged by a sticky overflow bit.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two and at least 2
ADDR_BITS, $clog2(DEPTH), localparam; width of the read/write pointers
COUNT_BITS, ADDR_BITS+1, localparam; width of the occupancy count (range 0..DEPTH)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock
in_valid  input  1  single-cycle strobe from the UART receiver: in_byte is valid this cycle
in_byte  input  8  received byte
out_valid  output  1  head entry present (FIFO not empty)
out_byte  output  8  head entry; meaningful only while out_valid=1
out_ready  input  1  consumer accepts the head this cycle
count  output  COUNT_BITS  current occupancy
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: at least one byte was dropped
clear_overflow  input  1  synchronous clear for overflow

Behaviour:
- Reset (reset=0, asynchronous): write pointer=0, read pointer=0, count=0, overflow=0, so out_valid=0, empty=1, full=0. Storage array is not reset; its contents are don't-care.
- Write: when in_valid=1 and (full=0 or a read occurs this cycle), write in_byte at the write pointer. The write pointer then increments modulo DEPTH.
- Read: a read occurs when out_valid=1 and out_ready=1. The read pointer then increments modulo DEPTH. out_ready while empty is ignored and has no side effects.
- FWFT latency: a byte written on edge N appears on out_byte with out_valid=1 immediately after edge N, i.e. it is visible in cycle N+1. The output path is an asynchronous read of the head entry; there is no extra register stage.
- Count:
  - write only: +1
  - read only: -1
  - read and write together: unchanged
  - count never exceeds DEPTH and never goes below 0.
- Full with a simultaneous read: the write is accepted, count stays DEPTH, and no overflow is raised.
- Empty with a simultaneous write: no read occurs (out_valid=0). Count goes to 1.
- Overflow set: in_valid=1, full=1, and no read in the same cycle. The byte is discarded, pointers and count are unchanged, and overflow goes to 1 on that edge.
- Overflow clear: clear_overflow=1 drives overflow to 0 on the next edge. If set and clear happen in the same cycle, set wins.
- Overflow is independent of data flow; draining the FIFO does not clear it.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Data order is strictly preserved across the wrap.
- Reset mid-operation: all queued bytes are lost, and outputs return to their reset values immediately on reset=0. Any partially received byte upstream is not this block's concern.
- in_valid is assumed to be at most one cycle per byte; consecutive-cycle strobes are each treated as separate bytes.
- empty, full and out_valid are derived combinationally from count. They have no separate state.

Decomposition:
- Shared package uart_pkg: BYTE_WIDTH=8; default BAUD_RATE=9600 and CLOCK_HZ=12_000_000 shared with the receiver and transmitter; a function for the pointer-width calculation.
- One sub-module, fifo_ram: simple dual-port storage, DEPTH x 8, with a synchronous write port (clock, write enable, write address, write data) and an asynchronous read port (read address, read data).
- Pointer, count and overflow logic stay in rx_fifo.

Test Plan:
1. Reset, then idle 10 cycles: count=0, empty=1, full=0, out_valid=0, overflow=0.
2. Write 0x41 with out_ready=0: out_valid=1 and out_byte=0x41 in the cycle after the strobe, count=1. Then pulse out_ready for one cycle: count=0, empty=1.
3. Write 0x00..0x0F (DEPTH=16): full=1, count=16. A 17th write of 0xAA gives overflow=1 and count=16. Draining returns 0x00..0x0F in order, with 0xAA never seen.
4. Wrap-around and order: write 10 bytes, read 10, write 12 bytes 0x80..0x8B, read all: data emerges in order 0x80..0x8B with no gaps and no repeated entries, and count ends at 0.
5. Full plus simultaneous read and write (0x55 in, head 0x00 out): count stays 16, overflow stays 0, and 0x55 becomes the last byte read.
6. Overflow set and clear: with overflow=1, assert clear_overflow, giving overflow=0 next cycle. Then assert a drop and clear_overflow in the same cycle: overflow=1. Finally assert reset low mid-stream with count=5: count=0 and out_valid=0 immediately.
